// File: rtl/volume_pkg.sv
// Shared constants and types for the volume ramp / gain stage.
// The VOLUME_ZC_EN macro (optional zero-cross gated stepping) is handled in volume_ramp.sv.
package volume_pkg;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_GAIN_W   = 8;

  // Gain is unsigned Q1.7: 128 is unity and 7 fractional bits are dropped after the multiply.
  localparam int UNITY_GAIN = 128;
  localparam int GAIN_FRAC  = 7;

  // Output clamp limits for the default 16-bit sample width.
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    MUTED   = 2'd0,
    RAMPING = 2'd1,
    IDLE    = 2'd2
  } vol_state_t;

endpackage

// File: rtl/gain_sat_mul.sv
// Two-stage gain multiplier for one channel.
// Stage 1 registers sample * gain. Stage 2 shifts the product right by GAIN_FRAC,
// rounding toward -inf, then clamps to the sample range.
// The valid strobe follows the data through both stages. Both data registers
// hold their value between strobes.
module gain_sat_mul
  import volume_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int GAIN_W   = DEF_GAIN_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strobe,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [GAIN_W-1:0]   gain,
  output logic [SAMPLE_W-1:0] result,
  output logic                result_valid
);

  localparam int PW = SAMPLE_W + GAIN_W + 1;
  localparam logic signed [PW-1:0] MAXV = {{(PW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] prod_d;
  logic signed [PW-1:0] prod_q;
  logic signed [PW-1:0] shifted;
  logic [SAMPLE_W-1:0]  sat;
  logic                 stage1_valid;

  // Widen both operands to the full product width.
  // The product is at most 2^(SAMPLE_W-1) * (2^GAIN_W - 1), so it cannot wrap.
  always_comb begin
    sample_ext = {{(GAIN_W+1){sample[SAMPLE_W-1]}}, sample};
    gain_ext   = {{(SAMPLE_W+1){1'b0}}, gain};
    prod_d     = sample_ext * gain_ext;
  end

  // Stage 1: capture the product on a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q       <= '0;
      stage1_valid <= 1'b0;
    end else begin
      stage1_valid <= strobe;
      if (strobe) prod_q <= prod_d;
    end
  end

  // Arithmetic shift rounds toward -inf, then clamp to the sample range.
  always_comb begin
    shifted = prod_q >>> GAIN_FRAC;
    if (shifted > MAXV)      sat = MAXV[SAMPLE_W-1:0];
    else if (shifted < MINV) sat = MINV[SAMPLE_W-1:0];
    else                     sat = shifted[SAMPLE_W-1:0];
  end

  // Stage 2: drive the output and hold it until the next sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= stage1_valid;
      if (stage1_valid) result <= sat;
    end
  end

endmodule

// File: rtl/volume_ramp.sv
// Stereo output gain/mute stage with a click-free gain ramp.
// On every sample strobe the gain moves up to STEP toward its effective target.
// The effective target is 0 while muted, otherwise gain_target_in.
// Each sample is scaled by the gain in effect before that strobe's update.
// Optional macro VOLUME_ZC_EN: a step is applied only at a left-channel sign
// change, or once ZC_TIMEOUT strobes have passed without a crossing.
//
// state   | meaning
// --------+-----------------------------------------------
// MUTED   | gain_cur == 0 and effective target == 0
// RAMPING | gain_cur != effective target (step pending)
// IDLE    | gain_cur == effective target, non-zero
module volume_ramp
  import volume_pkg::*;
#(
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int GAIN_W     = DEF_GAIN_W,
  parameter int STEP       = 1,
  parameter int ZC_TIMEOUT = 64
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sample_valid_in,
  input  logic                mute_in,
  input  logic [GAIN_W-1:0]   gain_target_in,
  input  logic [SAMPLE_W-1:0] data_dry_l,
  input  logic [SAMPLE_W-1:0] data_dry_r,
  output logic [SAMPLE_W-1:0] data_wet_l,
  output logic [SAMPLE_W-1:0] data_wet_r,
  output logic                data_valid_out,
  output logic                ramp_busy_out
);

  if (STEP < 1 || ZC_TIMEOUT < 1) begin : g_bad_param
    $error("volume_ramp: STEP and ZC_TIMEOUT must both be at least 1");
  end

  localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);

  vol_state_t        state;
  vol_state_t        state_next;
  logic [GAIN_W-1:0] gain_cur;
  logic [GAIN_W-1:0] gain_next;
  logic [GAIN_W-1:0] gain_stepped;
  logic [GAIN_W-1:0] eff_target;
  logic              step_ok;
  logic              valid_l;
  logic              valid_r;

  // Mute overrides the requested gain.
  always_comb eff_target = mute_in ? '0 : gain_target_in;

  // Move one step toward the target. Snap to the target when within STEP, so it never overshoots.
  always_comb begin
    gain_stepped = gain_cur;
    if (eff_target > gain_cur) begin
      if ((eff_target - gain_cur) <= STEP_G) gain_stepped = eff_target;
      else                                   gain_stepped = gain_cur + STEP_G;
    end else if (eff_target < gain_cur) begin
      if ((gain_cur - eff_target) <= STEP_G) gain_stepped = eff_target;
      else                                   gain_stepped = gain_cur - STEP_G;
    end
  end

`ifdef VOLUME_ZC_EN
  localparam int                  ZC_CNT_W = $clog2(ZC_TIMEOUT + 1);
  localparam logic [ZC_CNT_W-1:0] ZC_LOAD  = ZC_CNT_W'(ZC_TIMEOUT - 1);

  logic                prev_neg;
  logic                prev_zero;
  logic                cur_neg;
  logic                cur_zero;
  logic                crossing;
  logic                need_step;
  logic [ZC_CNT_W-1:0] zc_cnt;

  // A step is allowed at a sign change or zero, or once the timeout reaches terminal count.
  always_comb begin
    cur_neg   = data_dry_l[SAMPLE_W-1];
    cur_zero  = (data_dry_l == '0);
    crossing  = cur_zero || prev_zero || (cur_neg != prev_neg);
    need_step = (gain_cur != eff_target);
    step_ok   = crossing || (zc_cnt == '0);
  end

  // Track the left sample history. The timeout down-counter reloads after each applied step.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prev_neg  <= 1'b0;
      prev_zero <= 1'b0;
      zc_cnt    <= ZC_LOAD;
    end else if (sample_valid_in) begin
      prev_neg  <= cur_neg;
      prev_zero <= cur_zero;
      if (!need_step || step_ok) zc_cnt <= ZC_LOAD;
      else                       zc_cnt <= zc_cnt - 1'b1;
    end
  end
`else
  // Without zero-cross gating, every strobe may step.
  always_comb step_ok = 1'b1;
`endif

  // The gain changes only on strobes where a step is allowed.
  always_comb begin
    gain_next = gain_cur;
    if (sample_valid_in && step_ok) gain_next = gain_stepped;
  end

  // Gain register: soft start from silence after reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) gain_cur <= '0;
    else         gain_cur <= gain_next;
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= MUTED;
    else         state <= state_next;
  end

  // Next state follows from the gain after this strobe's update.
  always_comb begin
    state_next = state;
    if (sample_valid_in) begin
      if (gain_next != eff_target) state_next = RAMPING;
      else if (eff_target == '0)   state_next = MUTED;
      else                         state_next = IDLE;
    end
  end

  // FSM outputs.
  always_comb ramp_busy_out = (state == RAMPING);

  gain_sat_mul #(
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (GAIN_W)
  ) u_mul_l (
    .clk          (clk_in),
    .rst_n        (rst_in),
    .strobe       (sample_valid_in),
    .sample       (data_dry_l),
    .gain         (gain_cur),
    .result       (data_wet_l),
    .result_valid (valid_l)
  );

  gain_sat_mul #(
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (GAIN_W)
  ) u_mul_r (
    .clk          (clk_in),
    .rst_n        (rst_in),
    .strobe       (sample_valid_in),
    .sample       (data_dry_r),
    .gain         (gain_cur),
    .result       (data_wet_r),
    .result_valid (valid_r)
  );

  assign data_valid_out = valid_l & valid_r;

endmodule

// File: tb/tb_volume_ramp.sv
// Bench for volume_ramp: STEP=4 and STEP=1 instances share stimulus.
// Expectations come from a gain-ramp and floor/clamp arithmetic model.
module tb_volume_ramp;
  import volume_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sample_valid_in;
  logic        mute_in;
  logic [7:0]  gain_target_in;
  logic [15:0] data_dry_l;
  logic [15:0] data_dry_r;
  logic [15:0] wet_l4, wet_r4, wet_l1, wet_r1;
  logic        dv4, dv1, busy4, busy1;

  int checks = 0;
  int errors = 0;
  int gm[2];
  int steps[2];

  always #5 clk_in = ~clk_in;

  volume_ramp #(.STEP(4)) u_s4 (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .mute_in         (mute_in),
    .gain_target_in  (gain_target_in),
    .data_dry_l      (data_dry_l),
    .data_dry_r      (data_dry_r),
    .data_wet_l      (wet_l4),
    .data_wet_r      (wet_r4),
    .data_valid_out  (dv4),
    .ramp_busy_out   (busy4)
  );

  volume_ramp #(.STEP(1)) u_s1 (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .mute_in         (mute_in),
    .gain_target_in  (gain_target_in),
    .data_dry_l      (data_dry_l),
    .data_dry_r      (data_dry_r),
    .data_wet_l      (wet_l1),
    .data_wet_r      (wet_r1),
    .data_valid_out  (dv1),
    .ramp_busy_out   (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // out = floor(x * g / 128), clamped to the 16-bit signed range
  function automatic logic [15:0] ref_out(input int x, input int g);
    int p, q;
    p = x * g;
    q = p / UNITY_GAIN;
    if (p < 0 && (p % UNITY_GAIN) != 0) q = q - 1;
    if (q > SAT_MAX) q = SAT_MAX;
    if (q < SAT_MIN) q = SAT_MIN;
    return 16'(q);
  endfunction

  function automatic int ref_step(input int g, input int t, input int s);
    if (t > g) return (t - g <= s) ? t : g + s;
    if (t < g) return (g - t <= s) ? t : g - s;
    return g;
  endfunction

  task automatic do_strobe(input logic signed [15:0] l, input logic signed [15:0] r, input int gap);
    logic [15:0] el[2];
    logic [15:0] er[2];
    int t;
    t = mute_in ? 0 : int'(gain_target_in);
    for (int i = 0; i < 2; i++) begin
      el[i] = ref_out(int'(l), gm[i]);
      er[i] = ref_out(int'(r), gm[i]);
      gm[i] = ref_step(gm[i], t, steps[i]);
    end
    data_dry_l = l;
    data_dry_r = r;
    sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    chk("dv_n1_s4", dv4, 0);
    chk("dv_n1_s1", dv1, 0);
    chk("busy_s4", busy4, gm[0] != t);
    chk("busy_s1", busy1, gm[1] != t);
    @(posedge clk_in); #1;
    chk("dv_n2_s4", dv4, 1);
    chk("dv_n2_s1", dv1, 1);
    chk("wet_l_s4", wet_l4, el[0]);
    chk("wet_r_s4", wet_r4, er[0]);
    chk("wet_l_s1", wet_l1, el[1]);
    chk("wet_r_s1", wet_r1, er[1]);
    @(posedge clk_in); #1;
    chk("dv_n3_s4", dv4, 0);
    chk("dv_n3_s1", dv1, 0);
    chk("hold_l_s4", wet_l4, el[0]);
    chk("hold_r_s1", wet_r1, er[1]);
    repeat (gap) @(posedge clk_in);
    #1;
  endtask

  initial begin
    steps = '{4, 1};
    gm = '{0, 0};
    rst_in = 1'b0;
    sample_valid_in = 1'b0;
    mute_in = 1'b0;
    gain_target_in = 8'd128;
    data_dry_l = '0;
    data_dry_r = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_wet_l", wet_l4, 0);
    chk("rst_wet_r", wet_r1, 0);
    chk("rst_dv_s4", dv4, 0);
    chk("rst_dv_s1", dv1, 0);
    chk("rst_busy_s4", busy4, 0);
    chk("rst_busy_s1", busy1, 0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    // 1: soft start to unity; STEP 4 settles on strobe 32
    for (int k = 1; k <= 40; k++) begin
      do_strobe(16'sh1000, 16'sh1000, 2);
      chk("t1_busy_k", busy4, 32'(k < 32));
    end
    chk("t1_out", wet_l4, 16'h1000);

    // 2: let STEP 1 settle, then unity passthrough
    for (int k = 0; k < 100; k++) do_strobe(16'($urandom), 16'($urandom), 0);
    do_strobe(16'sh1234, -16'sh1234, 1);
    chk("t2_l_s4", wet_l4, 16'h1234);
    chk("t2_r_s4", wet_r4, 16'hEDCC);
    chk("t2_l_s1", wet_l1, 16'h1234);
    chk("t2_r_s1", wet_r1, 16'hEDCC);

    // 3: saturation at gain 255
    gain_target_in = 8'd255;
    for (int k = 0; k < 140; k++) do_strobe(16'($urandom), 16'($urandom), 0);
    do_strobe(16'sh7000, -16'sh7000, 0);
    chk("t3_sat_hi", wet_l1, 16'h7FFF);
    chk("t3_sat_lo", wet_r4, 16'h8000);

    // 4: floor rounding at gain 64
    gain_target_in = 8'd64;
    for (int k = 0; k < 200; k++) do_strobe(16'($urandom), 16'($urandom), 0);
    do_strobe(-16'sd1, 16'sd1, 0);
    chk("t4_neg1", wet_l1, 16'hFFFF);
    chk("t4_pos1", wet_r1, 16'h0000);

    // 5: mute mid-ramp at gain 50, then unmute back to unity
    mute_in = 1'b1;
    for (int k = 0; k < 70; k++) do_strobe(16'($urandom), 16'($urandom), 0);
    mute_in = 1'b0;
    gain_target_in = 8'd128;
    for (int k = 0; k < 50; k++) do_strobe(16'($urandom), 16'($urandom), 0);
    mute_in = 1'b1;
    for (int k = 0; k < 55; k++) do_strobe(16'($urandom), 16'($urandom), 0);
    chk("t5_muted_busy", busy1, 0);
    chk("t5_muted_out", wet_l1, 0);
    mute_in = 1'b0;
    for (int k = 0; k < 130; k++) do_strobe(16'($urandom), 16'($urandom), 0);
    chk("t5_unmuted_busy", busy1, 0);

    // random targets, mute toggles and gaps
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) gain_target_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0) mute_in = ~mute_in;
      do_strobe(16'($urandom), 16'($urandom), int'($urandom_range(0, 5)));
    end

    // 6: reset at N+1 of a strobe suppresses the output pulse
    mute_in = 1'b0;
    gain_target_in = 8'd128;
    data_dry_l = 16'h4000;
    data_dry_r = 16'h4000;
    sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    rst_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_in); #1;
      chk("t6_dv_s4", dv4, 0);
      chk("t6_dv_s1", dv1, 0);
      chk("t6_wet", wet_l4, 0);
    end
    rst_in = 1'b1;
    gm = '{0, 0};
    @(posedge clk_in); #1;
    for (int k = 0; k < 10; k++) do_strobe(16'sh4000, -16'sh4000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/volume_ramp.md
Name: volume_ramp

Overview:
Output gain/mute stage between the limiter and the I2S transmitter on the 22.579 MHz audio clock. Applies a per-frame stereo gain that ramps smoothly toward its target, which avoids zipper noise and clicks on mute, unmute and volume changes. Runs on the one-cycle sample strobe once per LR frame. Provides soft start after reset by ramping up from silence.

Parameters:
SAMPLE_W, 16, sample width (signed two's complement)
GAIN_W, 8, gain width; unsigned Q1.7, 128 = unity, 255 ≈ 1.99
STEP, 1, gain increment/decrement applied per sample strobe while ramping
ZC_TIMEOUT, 64, samples to wait for a zero crossing before forcing a step (VOLUME_ZC_EN only)

Ports:
clk_in  input  1  audio clock, 22.579 MHz
rst_in  input  1  asynchronous, active-low reset
sample_valid_in  input  1  one-cycle strobe per LR frame; data_dry_* valid on this cycle
mute_in  input  1  level; 1 = ramp to zero and hold
gain_target_in  input  GAIN_W  requested gain; sampled on every strobe
data_dry_l  input  SAMPLE_W  left input sample
data_dry_r  input  SAMPLE_W  right input sample
data_wet_l  output  SAMPLE_W  left output, held between strobes
data_wet_r  output  SAMPLE_W  right output, held between strobes
data_valid_out  output  1  one-cycle strobe when data_wet_* update
ramp_busy_out  output  1  1 while state == RAMPING

Behaviour:
- Reset (rst_in low, asynchronous): data_wet_l/r = 0, data_valid_out = 0, ramp_busy_out = 0, gain_cur = 0, state = MUTED, pipeline regs = 0.
- eff_target = mute_in ? 0 : gain_target_in, evaluated on each strobe.
- States: IDLE (gain_cur == eff_target != 0), RAMPING (gain_cur != eff_target), MUTED (gain_cur == 0 and eff_target == 0).
- Transitions occur only on strobe cycles. A state with gain_cur != eff_target goes to RAMPING. In RAMPING, reaching eff_target goes to IDLE, or to MUTED if the target is 0.
- Pipeline: strobe at cycle N. At N+1, stage 1 registers prod = signed(data_dry) * {1'b0, gain_cur} (SAMPLE_W+GAIN_W+1 bits) for both channels. At N+2, stage 2 arithmetic-shifts right by 7 (floor toward -inf), saturates to [-2^15, 2^15-1], drives data_wet_* and pulses data_valid_out. Latency is fixed at 2 cycles.
- The gain update happens at N+1. The sample at strobe N uses gain_cur before the update.
- Step rule: if |eff_target - gain_cur| <= STEP, gain_cur = eff_target (no overshoot). Otherwise gain_cur moves by ±STEP toward eff_target.
- A target change mid-ramp retargets immediately, with direction reversal allowed. No restart delay.
- mute_in has priority over gain_target_in. Toggling mute mid-ramp reverses the ramp from the current gain.
- A strobe arriving while stage 2 is still pending is not a supported input: strobes must be at least 3 cycles apart. Real frames are 512 cycles apart.
- Between strobes, all outputs hold. data_valid_out is never high for 2 consecutive cycles.
- Reset asserted mid-ramp or mid-pipeline clears everything, with no output pulse. After release the block soft-starts from gain 0.

Optional Feature:
VOLUME_ZC_EN.
- Defined: a gain step is applied only on strobes where the sign of data_dry_l differs from the previous left sample (or either sample is 0). A step is also forced if ZC_TIMEOUT strobes pass without a crossing. The timeout counter resets on every applied step. ramp_busy_out stays high while a step is pending.
- Not defined: steps apply on every strobe; no sign or timeout registers are synthesised.

Decomposition:
- Package volume_pkg holds:
  - SAMPLE_W and GAIN_W defaults
  - UNITY_GAIN = 128
  - GAIN_FRAC = 7
  - SAT_MAX / SAT_MIN constants
  - enum vol_state_t {MUTED, RAMPING, IDLE}
- Sub-module gain_sat_mul: a 2-stage registered multiply → shift → saturate, with valid pass-through. It is instantiated once per channel. The state machine and gain register stay in volume_ramp.

Test Plan:
1. Reset, target 128, STEP 4, no mute, 40 strobes with input 0x1000. Gain reaches 128 after exactly 32 strobes. ramp_busy_out then drops. Subsequent outputs are 0x1000, 2 cycles after each strobe.
2. Unity passthrough: gain settled at 128, inputs L = 0x1234, R = 0xEDCC. At N+2, outputs are 0x1234 / 0xEDCC and data_valid_out is high for one cycle.
3. Saturation: gain 255, inputs +0x7000 / -0x7000. Outputs are 0x7FFF / 0x8000.
4. Floor rounding: gain 64, input -1 gives -1; input +1 gives 0.
5. Mute mid-ramp: ramp 0→128 at STEP 1, assert mute_in at gain 50. Gain decreases 49, 48, … 0, then state is MUTED and outputs are 0. Deasserting mute_in ramps back to 128.
6. Reset at N+1 of a strobe: data_valid_out never pulses and outputs are 0. After release, gain starts at 0 (with VOLUME_ZC_EN, the step waits for a sign change or 64 strobes).
